skew_feeder: RTL and testbench



---
 rtl/skew_feeder_if.sv | 36 +++
 rtl/skew_feeder.sv | 155 +++++++++++++++
 tb/tb_skew_feeder.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/skew_feeder_if.sv
// Stream-side bundle of the skew feeder: the operand input handshake and the
// registered vector/enable bus that feeds the skew register bank.
interface skew_feeder_if #(
    parameter int DATA_WIDTH = 16,
    parameter int N          = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_WIDTH*N-1:0] in_data;
    logic                    array_ready;
    logic [DATA_WIDTH*N-1:0] out_data;
    logic                    out_en;
    logic                    out_last;

    // Environment side: produces operand vectors, consumes the skew-bank bus.
    modport master (
        output in_valid,
        output in_data,
        output array_ready,
        input  in_ready,
        input  out_data,
        input  out_en,
        input  out_last
    );

    // Feeder side.
    modport slave (
        input  in_valid,
        input  in_data,
        input  array_ready,
        output in_ready,
        output out_data,
        output out_en,
        output out_last
    );
endinterface

// File: rtl/skew_feeder.sv
// Upstream stage of the systolic skew register bank. Buffers a burst of `len`
// N-lane vectors in a small FIFO, emits them one per advance with a registered
// enable, then injects N-1 zero vectors so every skew lane drains, and finally
// pulses done.
module skew_feeder #(
    parameter int DATA_WIDTH = 16,
    parameter int N          = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] len,
    skew_feeder_if.slave         bus,
    output logic                 busy,
    output logic                 done
);
    localparam int VEC_W = DATA_WIDTH * N;
    localparam int AW    = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FLUSH,
        DONE
    } state_t;

    // With a single lane there is nothing to drain, so the last data vector
    // goes straight to DONE.
    localparam state_t AFTER_DATA = (N > 1) ? FLUSH : DONE;
    localparam logic [LEN_WIDTH-1:0] FLUSH_LAST = LEN_WIDTH'((N > 1) ? N - 2 : 0);

    state_t state, state_next;

    logic [VEC_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             full, empty;
    logic             ready, push, pop, flush_emit, load;
    logic             last_vec, last_flush;

    logic [LEN_WIDTH-1:0] len_q, acc_cnt, emit_cnt, flush_cnt;

    logic [VEC_W-1:0] out_data_q;
    logic             out_en_q, out_last_q, done_q;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // No same-cycle pop credit: a full FIFO never accepts.
    assign ready = (state == STREAM) && !full && (acc_cnt < len_q);
    assign push  = bus.in_valid && ready;

    assign last_vec   = (emit_cnt == len_q - LEN_WIDTH'(1));
    assign last_flush = (flush_cnt == FLUSH_LAST);

    assign bus.in_ready = ready;
    assign bus.out_data = out_data_q;
    assign bus.out_en   = out_en_q;
    assign bus.out_last = out_last_q;
    assign busy         = (state == STREAM) || (state == FLUSH);
    assign done         = done_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state and per-cycle pop/flush/load decisions.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        flush_emit = 1'b0;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = (len == '0) ? DONE : STREAM;
                end
            end
            STREAM: begin
                if (!empty && bus.array_ready) begin
                    pop = 1'b1;
                    if (last_vec) state_next = AFTER_DATA;
                end
            end
            FLUSH: begin
                if (bus.array_ready) begin
                    flush_emit = 1'b1;
                    if (last_flush) state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Burst length latch and accept/emit/flush counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q     <= '0;
            acc_cnt   <= '0;
            emit_cnt  <= '0;
            flush_cnt <= '0;
        end else begin
            if (load) begin
                len_q     <= len;
                acc_cnt   <= '0;
                emit_cnt  <= '0;
                flush_cnt <= '0;
            end
            if (push)       acc_cnt   <= acc_cnt + LEN_WIDTH'(1);
            if (pop)        emit_cnt  <= emit_cnt + LEN_WIDTH'(1);
            if (flush_emit) flush_cnt <= flush_cnt + LEN_WIDTH'(1);
        end
    end

    // FIFO pointers; the extra MSB tells full from empty and wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // FIFO storage; contents are don't-care while the pointers say empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= bus.in_data;
    end

    // Registered skew-bank bus and done pulse; out_data holds while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q <= '0;
            out_en_q   <= 1'b0;
            out_last_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            out_en_q   <= pop || flush_emit;
            out_last_q <= pop && last_vec;
            done_q     <= (state == DONE);
            if (pop)             out_data_q <= mem[rd_ptr[AW-1:0]];
            else if (flush_emit) out_data_q <= '0;
        end
    end
endmodule

// File: tb/tb_skew_feeder.sv
// Directed bench for skew_feeder: a 4-lane instance for burst, backpressure,
// flush-stall, zero-length and reset cases, and a 1-lane instance for the
// single-vector no-flush case.
module tb_skew_feeder;
    localparam int DW = 16;
    localparam int LW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, start1, busy, done, busy1, done1;
    logic [LW-1:0] len, len1;

    skew_feeder_if #(.DATA_WIDTH(DW), .N(4)) bus4 ();
    skew_feeder_if #(.DATA_WIDTH(DW), .N(1)) bus1 ();

    skew_feeder #(.DATA_WIDTH(DW), .N(4), .FIFO_DEPTH(4), .LEN_WIDTH(LW)) dut4 (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .bus(bus4.slave), .busy(busy), .done(done)
    );

    skew_feeder #(.DATA_WIDTH(DW), .N(1), .FIFO_DEPTH(4), .LEN_WIDTH(LW)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .len(len1),
        .bus(bus1.slave), .busy(busy1), .done(done1)
    );

    int n_asserts = 0;
    int n_fail    = 0;

    logic [63:0] src_q[$];
    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];
    logic [31:0] ar_low, start_pat, en_m, last_m, done_m, acc_m;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] v4(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    task automatic start_burst(input logic [LW-1:0] l);
        start = 1'b1;
        len   = l;
        step();
        start = 1'b0;
    endtask

    // Runs the 4-lane instance for a fixed number of cycles, feeding src_q
    // whenever it is ready and recording per-cycle masks of what came out.
    task automatic run(input int cycles);
        logic xfer;
        en_m = '0; last_m = '0; done_m = '0; acc_m = '0;
        got_q.delete();
        for (int i = 0; i < cycles; i++) begin
            bus4.array_ready = !ar_low[i];
            start            = start_pat[i];
            len              = 16'd7;
            bus4.in_valid    = (src_q.size() > 0);
            bus4.in_data     = (src_q.size() > 0) ? src_q[0] : {$urandom, $urandom};
            xfer             = bus4.in_valid && bus4.in_ready;
            step();
            if (xfer) begin
                void'(src_q.pop_front());
                acc_m[i] = 1'b1;
            end
            en_m[i]   = bus4.out_en;
            last_m[i] = bus4.out_last;
            done_m[i] = done;
            if (bus4.out_en) got_q.push_back(bus4.out_data);
        end
        start            = 1'b0;
        bus4.in_valid    = 1'b0;
        bus4.array_ready = 1'b1;
    endtask

    task automatic check_run(input string tag, input logic [31:0] e_en, input logic [31:0] e_last,
                             input logic [31:0] e_done, input logic [31:0] e_acc);
        chk({tag, ".en_mask"},   64'(en_m),   64'(e_en));
        chk({tag, ".last_mask"}, 64'(last_m), 64'(e_last));
        chk({tag, ".done_mask"}, 64'(done_m), 64'(e_done));
        chk({tag, ".acc_mask"},  64'(acc_m),  64'(e_acc));
        chk({tag, ".count"},     64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s.vec%0d", tag, i), (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; start1 = 1'b0; len1 = '0;
        bus4.in_valid = 1'b0; bus4.in_data = '0; bus4.array_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.array_ready = 1'b0;
        ar_low = '0; start_pat = '0;

        // Reset held two cycles, then idle with no start.
        step();
        step();
        chk("reset.ctl", 64'({bus4.out_en, bus4.out_last, busy, done, bus4.in_ready}), 64'(0));
        chk("reset.data", bus4.out_data, 64'(0));
        chk("reset.n1", 64'({bus1.out_en, bus1.out_last, busy1, done1, bus1.in_ready}), 64'(0));
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk($sformatf("idle.ctl%0d", i),
                64'({bus4.out_en, bus4.out_last, busy, done, bus4.in_ready}), 64'(0));
            chk($sformatf("idle.data%0d", i), bus4.out_data, 64'(0));
        end

        // Basic burst, len=3, no backpressure.
        bus4.array_ready = 1'b1;
        start_burst(3);
        chk("basic.busy", 64'(busy), 64'(1));
        chk("basic.ready", 64'(bus4.in_ready), 64'(1));
        src_q = '{v4(1, 2, 3, 4), v4(5, 6, 7, 8), v4(9, 10, 11, 12)};
        exp_q = '{v4(1, 2, 3, 4), v4(5, 6, 7, 8), v4(9, 10, 11, 12), 64'(0), 64'(0), 64'(0)};
        run(10);
        check_run("basic", 32'h7E, 32'h08, 32'h80, 32'h07);
        chk("basic.idle", 64'(busy), 64'(0));

        // Backpressure: FIFO fills after 4 accepts while array_ready is low.
        src_q.delete();
        exp_q.delete();
        for (int k = 0; k < 8; k++) begin
            src_q.push_back(v4(16 * k + 1, 16 * k + 2, 16 * k + 3, 16 * k + 4));
            exp_q.push_back(v4(16 * k + 1, 16 * k + 2, 16 * k + 3, 16 * k + 4));
        end
        for (int k = 0; k < 3; k++) exp_q.push_back(64'(0));
        start_burst(8);
        ar_low = 32'h3FF;
        run(24);
        check_run("bp", 32'h1FFC00, 32'h20000, 32'h200000, 32'h780F);
        ar_low = '0;

        // Stall in mid-flush, with start pulses during STREAM and FLUSH ignored.
        src_q = '{v4(17, 34, 51, 68), v4(85, 102, 119, 136)};
        exp_q = '{v4(17, 34, 51, 68), v4(85, 102, 119, 136), 64'(0), 64'(0), 64'(0)};
        start_burst(2);
        ar_low    = 32'h70;
        start_pat = 32'h22;
        run(12);
        check_run("stall", 32'h18E, 32'h04, 32'h200, 32'h03);
        chk("stall.idle", 64'({busy, done}), 64'(0));
        ar_low    = '0;
        start_pat = '0;

        // Zero-length burst.
        exp_q.delete();
        start_burst(0);
        chk("len0.enter", 64'({busy, done, bus4.out_en}), 64'(0));
        run(4);
        check_run("len0", 32'h0, 32'h0, 32'h1, 32'h0);

        // Single lane, single vector: no flush.
        bus1.array_ready = 1'b1;
        start1 = 1'b1;
        len1   = 16'd1;
        step();
        start1 = 1'b0;
        chk("n1.busy", 64'(busy1), 64'(1));
        bus1.in_valid = 1'b1;
        bus1.in_data  = 16'hABCD;
        step();
        chk("n1.en_early", 64'(bus1.out_en), 64'(0));
        bus1.in_valid = 1'b0;
        bus1.in_data  = 16'h0;
        step();
        chk("n1.en_last", 64'({bus1.out_en, bus1.out_last, done1}), 64'(3'b110));
        chk("n1.data", 64'(bus1.out_data), 64'(16'hABCD));
        step();
        chk("n1.done", 64'({bus1.out_en, done1}), 64'(2'b01));
        step();
        chk("n1.idle", 64'({busy1, done1}), 64'(0));

        // Reset after two of five vectors are out, then a fresh burst.
        src_q.delete();
        for (int k = 0; k < 5; k++) src_q.push_back(v4(k + 200, k + 300, k + 400, k + 500));
        start_burst(5);
        run(3);
        chk("rstmid.count", 64'(got_q.size()), 64'(2));
        chk("rstmid.acc", 64'(acc_m), 64'(32'h7));
        rst = 1'b1;
        src_q.delete();
        step();
        chk("rstmid.ctl", 64'({bus4.out_en, bus4.out_last, busy, done, bus4.in_ready}), 64'(0));
        chk("rstmid.data", bus4.out_data, 64'(0));
        rst = 1'b0;
        src_q = '{v4(7, 7, 7, 7), v4(8, 9, 10, 11)};
        exp_q = '{v4(7, 7, 7, 7), v4(8, 9, 10, 11), 64'(0), 64'(0), 64'(0)};
        start_burst(2);
        run(8);
        check_run("fresh", 32'h3E, 32'h04, 32'h40, 32'h03);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
